// File: rtl/bf_pipe.sv
// -----------------------------------------------------------------------------
// bf_pipe
// Three-stage radix-2 butterfly with twiddle multiply on the difference path.
//   S1: A+B and A-B at full precision, then halve (scale_en=1) or saturate.
//   S2: four real products of the difference with the twiddle.
//   S3: complex combine, round half up, shift by TW-1, saturate to W bits.
// The sum path rides alongside S2/S3 so both results leave together.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is the pipeline advance
//   in_re0/in_im0       operand A (signed W)
//   in_re1/in_im1       operand B (signed W)
//   tw_re/tw_im         twiddle (signed Q1.(TW-1))
//   scale_en            per-beat: 1 halves S1 results, 0 saturates them
//   out_valid/out_ready output handshake
//   out_bf0             {im,re} of (A-B)*tw
//   out_bf1             {im,re} of A+B
//   ovf / ovf_clr       sticky saturation flag and its clear
// -----------------------------------------------------------------------------
module bf_pipe #(
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_re0,
    input  logic [W-1:0]   in_im0,
    input  logic [W-1:0]   in_re1,
    input  logic [W-1:0]   in_im1,
    input  logic [TW-1:0]  tw_re,
    input  logic [TW-1:0]  tw_im,
    input  logic           scale_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_bf0,
    output logic [2*W-1:0] out_bf1,
    output logic           ovf,
    input  logic           ovf_clr
);

    localparam int P = W + TW;
    localparam logic [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};
    // Half an LSB of the final result, added before the truncating shift.
    localparam logic [P:0] RND = {{(P-TW+2){1'b0}}, 1'b1, {(TW-2){1'b0}}};

    // Returns {saturated, value} for a W+1 bit S1 result.
    function automatic logic [W:0] reduceS1(input logic [W:0] x, input logic scale);
        logic [W:0] r;
        if (scale) begin
            r = {1'b0, x[W:1]};
        end else if (x[W] != x[W-1]) begin
            r = {1'b1, (x[W] ? MINW : MAXW)};
        end else begin
            r = {1'b0, x[W-1:0]};
        end
        return r;
    endfunction

    // Returns {saturated, value} for a P+1 bit S3 accumulator.
    function automatic logic [W:0] roundSat(input logic [P:0] acc);
        logic [P:0] rounded;
        logic [P:0] shifted;
        logic [W:0] r;
        rounded = acc + RND;
        shifted = $signed(rounded) >>> (TW-1);
        if ((&shifted[P:W-1]) || !(|shifted[P:W-1])) begin
            r = {1'b0, shifted[W-1:0]};
        end else begin
            r = {1'b1, (shifted[P] ? MINW : MAXW)};
        end
        return r;
    endfunction

    logic           adv;
    logic           s1Valid_q, s2Valid_q, outValid_q, ovf_q, ovf_d;
    logic [W-1:0]   s1SumRe_q, s1SumIm_q, s1DiffRe_q, s1DiffIm_q;
    logic [TW-1:0]  s1TwRe_q, s1TwIm_q;
    logic [P-1:0]   s2Prr_q, s2Pii_q, s2Pri_q, s2Pir_q;
    logic [W-1:0]   s2SumRe_q, s2SumIm_q;
    logic [2*W-1:0] outBf0_q, outBf1_q;

    logic [W:0]     sumRe, sumIm, diffRe, diffIm;
    logic [W:0]     redSumRe, redSumIm, redDiffRe, redDiffIm;
    logic [P-1:0]   dReX, dImX, tReX, tImX;
    logic [P:0]     accRe, accIm;
    logic [W:0]     resRe, resIm;
    logic           s1SetOvf, s3SetOvf;

    // The whole pipeline moves as one; reset forces in_ready high because
    // the pipeline is empty after the reset edge anyway.
    assign adv       = !outValid_q || out_ready;
    assign in_ready  = adv || rst;
    assign out_valid = outValid_q;
    assign out_bf0   = outBf0_q;
    assign out_bf1   = outBf1_q;
    assign ovf       = ovf_q;

    // Stage 1 arithmetic: sign-extend to W+1 bits so nothing is lost
    // before the halve/saturate decision.
    always_comb begin
        sumRe     = {in_re0[W-1], in_re0} + {in_re1[W-1], in_re1};
        sumIm     = {in_im0[W-1], in_im0} + {in_im1[W-1], in_im1};
        diffRe    = {in_re0[W-1], in_re0} - {in_re1[W-1], in_re1};
        diffIm    = {in_im0[W-1], in_im0} - {in_im1[W-1], in_im1};
        redSumRe  = reduceS1(sumRe, scale_en);
        redSumIm  = reduceS1(sumIm, scale_en);
        redDiffRe = reduceS1(diffRe, scale_en);
        redDiffIm = reduceS1(diffIm, scale_en);
        s1SetOvf  = in_valid && adv &&
                    (redSumRe[W] || redSumIm[W] || redDiffRe[W] || redDiffIm[W]);
    end

    // Stage 2 arithmetic: operands are sign-extended to the product width,
    // so a modulo-2^P multiply gives the exact signed product.
    always_comb begin
        dReX = {{TW{s1DiffRe_q[W-1]}}, s1DiffRe_q};
        dImX = {{TW{s1DiffIm_q[W-1]}}, s1DiffIm_q};
        tReX = {{W{s1TwRe_q[TW-1]}}, s1TwRe_q};
        tImX = {{W{s1TwIm_q[TW-1]}}, s1TwIm_q};
    end

    // Stage 3 arithmetic: one extra bit covers the sum of two full products.
    always_comb begin
        accRe    = {s2Prr_q[P-1], s2Prr_q} - {s2Pii_q[P-1], s2Pii_q};
        accIm    = {s2Pri_q[P-1], s2Pri_q} + {s2Pir_q[P-1], s2Pir_q};
        resRe    = roundSat(accRe);
        resIm    = roundSat(accIm);
        s3SetOvf = s2Valid_q && adv && (resRe[W] || resIm[W]);
    end

    // Sticky overflow: a set event beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (s1SetOvf || s3SetOvf) begin
            ovf_d = 1'b1;
        end
    end

    // Pipeline registers. Only valid beats load the output data so the
    // outputs stay put across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
            s1SumRe_q  <= '0;
            s1SumIm_q  <= '0;
            s1DiffRe_q <= '0;
            s1DiffIm_q <= '0;
            s1TwRe_q   <= '0;
            s1TwIm_q   <= '0;
            s2Prr_q    <= '0;
            s2Pii_q    <= '0;
            s2Pri_q    <= '0;
            s2Pir_q    <= '0;
            s2SumRe_q  <= '0;
            s2SumIm_q  <= '0;
            outBf0_q   <= '0;
            outBf1_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (adv) begin
                s1Valid_q  <= in_valid;
                s1SumRe_q  <= redSumRe[W-1:0];
                s1SumIm_q  <= redSumIm[W-1:0];
                s1DiffRe_q <= redDiffRe[W-1:0];
                s1DiffIm_q <= redDiffIm[W-1:0];
                s1TwRe_q   <= tw_re;
                s1TwIm_q   <= tw_im;

                s2Valid_q  <= s1Valid_q;
                s2Prr_q    <= dReX * tReX;
                s2Pii_q    <= dImX * tImX;
                s2Pri_q    <= dReX * tImX;
                s2Pir_q    <= dImX * tReX;
                s2SumRe_q  <= s1SumRe_q;
                s2SumIm_q  <= s1SumIm_q;

                outValid_q <= s2Valid_q;
                if (s2Valid_q) begin
                    outBf0_q <= {resIm[W-1:0], resRe[W-1:0]};
                    outBf1_q <= {s2SumIm_q, s2SumRe_q};
                end
            end
        end
    end

endmodule

// File: tb/tb_bf_pipe.sv
// -----------------------------------------------------------------------------
// tb_bf_pipe
// Directed bench for bf_pipe at W=16, TW=16. Inputs change 1 ns after the
// rising edge; outputs are checked there or at the falling edge.
// -----------------------------------------------------------------------------
module tb_bf_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, scale_en;
    logic        out_valid, out_ready, ovf, ovf_clr;
    logic [15:0] in_re0, in_im0, in_re1, in_im1, tw_re, tw_im;
    logic [31:0] out_bf0, out_bf1;

    int assertCount = 0;
    int failCount   = 0;
    int inIdx, outIdx;

    bf_pipe #(.W(16), .TW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re0(in_re0), .in_im0(in_im0), .in_re1(in_re1), .in_im1(in_im1),
        .tw_re(tw_re), .tw_im(tw_im), .scale_en(scale_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bf0(out_bf0), .out_bf1(out_bf1),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Drives one input beat (or a bubble when valid is 0).
    task automatic applyStimulus(input logic v, input logic [15:0] re0, input logic [15:0] im0,
                                 input logic [15:0] re1, input logic [15:0] im1,
                                 input logic [15:0] twr, input logic [15:0] twi, input logic sc);
        in_valid = v;
        in_re0 = re0; in_im0 = im0; in_re1 = re1; in_im1 = im1;
        tw_re = twr; tw_im = twi; scale_en = sc;
    endtask

    // One comparison: counted, asserted, reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Moves to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream beat i: A=(100(i+1),10i), B=(2i,-4i), tw=(32767,0), halved.
    function automatic logic [31:0] streamBf1(input int i);
        logic [15:0] re, im;
        re = 16'(50 * (i + 1) + i);
        im = 16'(3 * i);
        return {im, re};
    endfunction

    function automatic logic [31:0] streamBf0(input int i);
        logic [15:0] re, im;
        re = 16'(50 * (i + 1) - i);
        im = 16'(7 * i);
        return {im, re};
    endfunction

    initial begin
        rst = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        applyStimulus(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        step(); step();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_bf0", out_bf0, 32'd0);
        checkOutput("rst_bf1", out_bf1, 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Basic halved beat, also checks the three-cycle latency.
        applyStimulus(1'b1, 16'd1000, 16'd200, 16'd600, -16'sd100, 16'd32767, 16'd0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        checkOutput("lat_early", 32'(out_valid), 32'd0);
        step();
        checkOutput("b1_valid", 32'(out_valid), 32'd1);
        checkOutput("b1_bf1", out_bf1, 32'h0032_0320);
        checkOutput("b1_bf0", out_bf0, 32'h0096_00C8);
        checkOutput("b1_ovf", 32'(ovf), 32'd0);
        step();
        checkOutput("b1_drain", 32'(out_valid), 32'd0);

        // Twiddle of -j with round/floor on both components.
        applyStimulus(1'b1, 16'd100, 16'd50, 16'd0, 16'd0, 16'd0, 16'h8000, 1'b0);
        step(); in_valid = 1'b0; step(); step();
        checkOutput("mj_valid", 32'(out_valid), 32'd1);
        checkOutput("mj_bf0", out_bf0, 32'hFF9C_0032);
        checkOutput("mj_bf1", out_bf1, 32'h0032_0064);
        checkOutput("mj_ovf", 32'(ovf), 32'd0);

        // Halving a negative odd value floors toward minus infinity.
        applyStimulus(1'b1, -16'sd3, 16'd0, 16'd0, 16'd0, 16'd32767, 16'd0, 1'b1);
        step(); in_valid = 1'b0; step(); step();
        checkOutput("floor_bf1", out_bf1, 32'h0000_FFFE);
        checkOutput("floor_bf0", out_bf0, 32'h0000_FFFE);

        // Saturation in S3 only: ovf rises when the beat reaches the output.
        applyStimulus(1'b1, 16'h8000, 16'h8000, 16'd0, 16'd0, 16'h8000, 16'h8000, 1'b0);
        step(); in_valid = 1'b0; step();
        checkOutput("s3_ovf_early", 32'(ovf), 32'd0);
        step();
        checkOutput("s3_ovf", 32'(ovf), 32'd1);
        checkOutput("s3_bf0", out_bf0, 32'h7FFF_0000);
        checkOutput("s3_bf1", out_bf1, 32'h8000_8000);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        checkOutput("s3_clr", 32'(ovf), 32'd0);

        // S1 saturation of the sum, ovf sticky until cleared.
        applyStimulus(1'b1, 16'd32767, 16'd0, 16'd32767, 16'd0, 16'd32767, 16'd0, 1'b0);
        step(); in_valid = 1'b0;
        checkOutput("sat_ovf_set", 32'(ovf), 32'd1);
        step(); step();
        checkOutput("sat_bf1", out_bf1, 32'h0000_7FFF);
        checkOutput("sat_bf0", out_bf0, 32'h0000_0000);
        step(); step(); step();
        checkOutput("sat_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        checkOutput("sat_clr", 32'(ovf), 32'd0);

        // Set and clear in the same cycle: set wins.
        applyStimulus(1'b1, 16'd32767, 16'd0, 16'd32767, 16'd0, 16'd32767, 16'd0, 1'b0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0; in_valid = 1'b0;
        checkOutput("set_wins", 32'(ovf), 32'd1);
        step(); step(); step();
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

        // Eight back-to-back beats with a five-cycle downstream stall.
        inIdx = 0; outIdx = 0;
        for (int c = 0; c < 60 && outIdx < 8; c++) begin
            if (inIdx < 8) begin
                applyStimulus(1'b1, 16'(100 * (inIdx + 1)), 16'(10 * inIdx), 16'(2 * inIdx),
                              16'(-4 * inIdx), 16'd32767, 16'd0, 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(c >= 5 && c < 10);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream_bf1_%0d", outIdx), out_bf1, streamBf1(outIdx));
                checkOutput($sformatf("stream_bf0_%0d", outIdx), out_bf0, streamBf0(outIdx));
                outIdx++;
            end
            if (in_valid && in_ready) begin
                inIdx++;
            end
            step();
        end
        checkOutput("stream_count", 32'(outIdx), 32'd8);
        checkOutput("stream_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1; in_valid = 1'b0;
        step(); step(); step();

        // Reset with three beats in flight and ovf set.
        applyStimulus(1'b1, 16'd32767, 16'd0, 16'd32767, 16'd0, 16'd32767, 16'd0, 1'b0);
        step();
        applyStimulus(1'b1, 16'd10, 16'd20, 16'd30, 16'd40, 16'd32767, 16'd0, 1'b1);
        step(); step();
        checkOutput("inflight_valid", 32'(out_valid), 32'd1);
        checkOutput("inflight_ovf", 32'(ovf), 32'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_in_ready_stall", 32'(in_ready), 32'd1);
        step();
        checkOutput("rst2_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst2_ovf", 32'(ovf), 32'd0);
        checkOutput("rst2_bf0", out_bf0, 32'd0);
        checkOutput("rst2_bf1", out_bf1, 32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("no_stale_%0d", k), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bf_pipe.md
BF_PIPE -- requirements
Module: bf_pipe

Interface
REQ-001 The module SHALL have parameter W, default 16, meaning the signed data width of each real and imaginary sample.
REQ-002 The module SHALL have parameter TW, default 16, meaning the signed twiddle width in Q1.(TW-1) format.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset; ports in order:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat present
in_ready  out  1  block accepts beat this cycle
in_re0, in_im0  in  W  operand A, signed
in_re1, in_im1  in  W  operand B, signed
tw_re, tw_im  in  TW  twiddle for difference path, signed
scale_en  in  1  1: halve stage-1 results; 0: saturate them
out_valid  out  1  output beat present
out_ready  in  1  downstream accepts beat
out_bf0  out  2W  {im,re} of (A-B)*tw
out_bf1  out  2W  {im,re} of A+B
ovf  out  1  sticky saturation flag
ovf_clr  in  1  clears ovf

Function
REQ-004 The block SHALL be a 3-stage pipeline: S1 add/sub, S2 four real products, S3 combine/round/saturate; the sum path SHALL be delayed to stay aligned.
REQ-005 All stages SHALL advance together when adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-006 A beat SHALL transfer in when in_valid && in_ready and out when out_valid && out_ready.
REQ-007 With out_ready held high, a beat accepted at cycle n SHALL appear with out_valid=1 at cycle n+3.
REQ-008 Each stage SHALL carry a valid bit; bubbles (in_valid=0 while adv) SHALL propagate as invalid slots, never as outputs.
REQ-009 When adv=0, all stage registers and outputs SHALL hold; no beat is lost, duplicated or reordered.
REQ-010 S1 SHALL compute sum = A+B and diff = A-B per component at W+1 bits, full precision.
REQ-011 scale_en SHALL be sampled with the beat and travel with it.
REQ-012 scale_en=1: S1 results SHALL be bits [W:1] (arithmetic shift right, floor); no overflow possible.
REQ-013 scale_en=0: S1 results SHALL saturate to [-2^(W-1), 2^(W-1)-1]; each saturated component SHALL set ovf.
REQ-014 S2 SHALL form dr*tr, di*ti, dr*ti, di*tr at W+TW bits each, signed.
REQ-015 S3 SHALL form re = dr*tr - di*ti, im = dr*ti + di*tr at W+TW+1 bits, add 2^(TW-2), shift right arithmetically by TW-1, then saturate to W bits; each saturation SHALL set ovf.
REQ-016 out_bf1 SHALL carry the S1 sum (scaled or saturated) unmodified by twiddle.
REQ-017 ovf SHALL be sticky; ovf_clr clears it; if a set event and ovf_clr coincide, set SHALL win; ovf set events SHALL occur only for valid beats at their transfer-advance.
REQ-018 out_bf0/out_bf1 SHALL be registered outputs; their value while out_valid=0 SHALL be don't-care but stable across stalls.

Reset
REQ-019 On rst=1 at a clock edge, all stage valid bits, out_valid and ovf SHALL become 0; out_bf0 and out_bf1 SHALL become 0.
REQ-020 Beats in flight at reset SHALL be discarded; rst SHALL override adv, in_valid and ovf set events.
REQ-021 During rst=1, in_ready SHALL be 1 (pipeline empty) but accepted beats SHALL be discarded.

Verification (W=16, TW=16)
REQ-022 A=(1000,200), B=(600,-100), tw=(32767,0), scale_en=1, out_ready=1 -> 3 cycles later out_bf1={50,800}, out_bf0={150,200}, ovf=0.
REQ-023 A=(32767,0), B=(32767,0), scale_en=0 -> out_bf1 re=32767 (saturated), out_bf0={0,0}, ovf=1 and stays 1 until ovf_clr.
REQ-024 A=(100,50), B=(0,0), tw=(0,-32768), scale_en=0 -> out_bf0={-100,50} (re=50, im=-100 after round/floor), ovf=0.
REQ-025 Stream 8 back-to-back beats, drop out_ready for 5 cycles mid-stream -> in_ready falls when out_valid && !out_ready, all 8 outputs emerge in order with correct values, none duplicated.
REQ-026 Pulse rst with 3 beats in flight and ovf=1 -> next cycle out_valid=0, ovf=0, outputs 0; no stale beat ever appears afterward.
REQ-027 Overflowing beat advancing in the same cycle as ovf_clr=1 -> ovf=1 next cycle.
